// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/CMD/LEN/payload/CHK byte-frame parser behind a UART receiver.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        frame_valid,
  output logic [7:0]  cmd,
  output logic [3:0]  len,
  output logic [63:0] payload,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [7:0] SOF = 8'hAA;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_LEN = 3'd2,
    GET_PAY = 3'd3,
    GET_CHK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        rdy_q;
  logic        accept;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  wcmd_q, wcmd_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [63:0] wpay_q, wpay_d;
  logic        fv_q, fv_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [3:0]  len_q, len_d;
  logic [63:0] pay_q, pay_d;
  logic        timeout_hit;

  // Reset clears rdy_q, so a rx_ready already high at release is seen as an edge.
  assign accept = rx_ready & ~rdy_q;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q, tmo_d;

  assign timeout_hit = (state_q != IDLE) && (tmo_q == CW'(TIMEOUT_CYC));

  always_comb begin
    tmo_d = '0;
    if (state_q != IDLE && !accept && !timeout_hit) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    wcmd_d  = wcmd_q;
    wlen_d  = wlen_q;
    wpay_d  = wpay_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    pay_d   = pay_q;

    // A timeout wins over a byte arriving in the same cycle; that byte is dropped.
    if (timeout_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == SOF) begin
            state_d = GET_CMD;
            wpay_d  = '0;
            acc_d   = '0;
            idx_d   = '0;
          end
        end
        GET_CMD: begin
          wcmd_d  = rx_data;
          acc_d   = rx_data;
          state_d = GET_LEN;
        end
        GET_LEN: begin
          if (rx_data > 8'(MAX_LEN)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = 2'd2;
          end else begin
            wlen_d  = rx_data[3:0];
            acc_d   = acc_q ^ rx_data;
            idx_d   = '0;
            state_d = (rx_data == 8'd0) ? GET_CHK : GET_PAY;
          end
        end
        GET_PAY: begin
          wpay_d[{idx_q, 3'b000} +: 8] = rx_data;
          acc_d = acc_q ^ rx_data;
          idx_d = idx_q + 3'd1;
          if ({1'b0, idx_q} == wlen_q - 4'd1) state_d = GET_CHK;
        end
        GET_CHK: begin
          state_d = IDLE;
          if (rx_data == acc_q) begin
            fv_d  = 1'b1;
            cmd_d = wcmd_q;
            len_d = wlen_q;
            pay_d = wpay_q;
          end else begin
            err_d  = 1'b1;
            code_d = 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      wcmd_q  <= '0;
      wlen_q  <= '0;
      wpay_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rx_ready;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      wcmd_q  <= wcmd_d;
      wlen_q  <= wlen_d;
      wpay_q  <= wpay_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
    end
  end

  assign frame_valid = fv_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign cmd         = cmd_q;
  assign len         = len_q;
  assign payload     = pay_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - table-driven self-checking bench for uart_frame_parser.
module tb_uart_frame_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic [3:0]  len;
  logic [63:0] payload;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int both_cnt = 0;

  uart_frame_parser #(.MAX_LEN(8), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .frame_valid(frame_valid), .cmd(cmd), .len(len), .payload(payload),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) vcnt++;
    if (err) ecnt++;
    if (frame_valid && err) both_cnt++;
  end

  typedef struct {
    logic [7:0]  bytes [12];
    int          nbytes;
    int          hold;
    int          exp_valid;
    int          exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_cmd;
    logic [3:0]  exp_len;
    logic [63:0] exp_pay;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_ready = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    rx_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input int i, input logic [7:0] b [12], input int n, input int hold,
                         input int ev, input int ee, input logic [1:0] ec,
                         input logic [7:0] ecmd, input logic [3:0] elen, input logic [63:0] epay);
    vecs[i].bytes     = b;
    vecs[i].nbytes    = n;
    vecs[i].hold      = hold;
    vecs[i].exp_valid = ev;
    vecs[i].exp_err   = ee;
    vecs[i].exp_code  = ec;
    vecs[i].exp_cmd   = ecmd;
    vecs[i].exp_len   = elen;
    vecs[i].exp_pay   = epay;
  endtask

  initial begin
    logic [7:0] b [12];
    int v0, e0;

    b = '{8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65, 0, 0, 0, 0, 0, 0};
    set_vec(0, b, 6, 1, 1, 0, 2'd0, 8'h10, 4'd2, 64'h4433);
    b = '{8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66, 0, 0, 0, 0, 0, 0};
    set_vec(1, b, 6, 1, 0, 1, 2'd1, 8'h10, 4'd2, 64'h4433);
    b = '{8'hAA, 8'h05, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    set_vec(2, b, 3, 1, 0, 1, 2'd2, 8'h10, 4'd2, 64'h4433);
    b = '{8'hAA, 8'h05, 8'h00, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0};
    set_vec(3, b, 4, 1, 1, 0, 2'd2, 8'h05, 4'd0, 64'h0);
    b = '{8'hAA, 8'h01, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01};
    set_vec(4, b, 12, 1, 1, 0, 2'd2, 8'h01, 4'd8, 64'h0807060504030201);
    // Short frame after a full one: upper payload bytes must read zero again.
    b = '{8'h00, 8'hFF, 8'h12, 8'hAA, 8'h20, 8'h01, 8'hAA, 8'h8B, 0, 0, 0, 0};
    set_vec(5, b, 8, 1, 1, 0, 2'd2, 8'h20, 4'd1, 64'hAA);
    b = '{8'hAA, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65, 0, 0, 0, 0, 0, 0};
    set_vec(6, b, 6, 5, 1, 0, 2'd2, 8'h10, 4'd2, 64'h4433);

    repeat (3) @(posedge clk);
    #1;
    check("reset frame_valid", {63'd0, frame_valid}, 64'd0);
    check("reset err", {63'd0, err}, 64'd0);
    check("reset err_code", {62'd0, err_code}, 64'd0);
    check("reset cmd", {56'd0, cmd}, 64'd0);
    check("reset len", {60'd0, len}, 64'd0);
    check("reset payload", payload, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      v0 = vcnt;
      e0 = ecnt;
      for (int k = 0; k < vecs[i].nbytes; k++) send_byte(vecs[i].bytes[k], vecs[i].hold);
      repeat (3) begin @(posedge clk); #1; end
      check($sformatf("v%0d valid_pulses", i), 64'(vcnt - v0), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d err_pulses", i), 64'(ecnt - e0), 64'(vecs[i].exp_err));
      check($sformatf("v%0d err_code", i), {62'd0, err_code}, {62'd0, vecs[i].exp_code});
      check($sformatf("v%0d cmd", i), {56'd0, cmd}, {56'd0, vecs[i].exp_cmd});
      check($sformatf("v%0d len", i), {60'd0, len}, {60'd0, vecs[i].exp_len});
      check($sformatf("v%0d payload", i), payload, vecs[i].exp_pay);
    end

    // Reset in the middle of a payload: outputs clear, no err pulse.
    e0 = ecnt;
    send_byte(8'hAA, 1);
    send_byte(8'h10, 1);
    send_byte(8'h03, 1);
    send_byte(8'h11, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst cmd", {56'd0, cmd}, 64'd0);
    check("midrst len", {60'd0, len}, 64'd0);
    check("midrst payload", payload, 64'd0);
    check("midrst err_code", {62'd0, err_code}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst err_pulses", 64'(ecnt - e0), 64'd0);

    // rx_ready already high at reset release counts as an SOF edge.
    v0 = vcnt;
    rx_data  = 8'hAA;
    rx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h30, 1);
    send_byte(8'h00, 1);
    send_byte(8'h30, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("held_at_release valid_pulses", 64'(vcnt - v0), 64'd1);
    check("held_at_release cmd", {56'd0, cmd}, 64'h30);

`ifdef UART_FRAME_TIMEOUT_EN
    e0 = ecnt;
    send_byte(8'hAA, 1);
    send_byte(8'h10, 1);
    repeat (40) begin @(posedge clk); #1; end
    check("timeout early err_pulses", 64'(ecnt - e0), 64'd0);
    repeat (20) begin @(posedge clk); #1; end
    check("timeout err_pulses", 64'(ecnt - e0), 64'd1);
    check("timeout err_code", {62'd0, err_code}, 64'd3);
`endif

    check("valid_and_err_overlap", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
